bnn_stream_popcount: RTL and testbench

Streaming binary-neural-network dot-product unit: the parametrised successor of the single-word XNOR/popcount stage. It accepts the XOR of packed weight and activation words over a valid/ready stream and accumulates the XNOR popcount across as many words as the configured vector length requires. This supports vectors longer than one register. It then emits either the signed score 2·popcount − N or a thresholded 0/1 activation on an output valid/ready stream. It sits behind the execute-stage ALU and is configured by the existing I-type matrix-size and activation-threshold instructions.

---
 rtl/bnn_stream_popcount.sv | 126 ++++++++++++
 tb/tb_bnn_stream_popcount.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_stream_popcount.sv
// Streaming BNN dot-product: accumulates XNOR popcounts over an N-bit vector split
// into XLEN-bit words, then emits the signed score 2*popcount-N or a thresholded bit.
module bnn_stream_popcount #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_ms_we,
    input  logic            cfg_at_we,
    input  logic [XLEN-1:0] cfg_wdata,
    input  logic            en_threshold,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        matrix_size;
    logic signed [XLEN-1:0]  act_threshold;
    logic [CNT_W-1:0]        acc;
    logic [CNT_W-1:0]        remaining;
    logic                    mode_act;

    logic                    accept;
    logic [CNT_W-1:0]        rem_cur;
    logic [CNT_W-1:0]        k;
    logic [CNT_W-1:0]        pop;
    logic [CNT_W-1:0]        acc_next;
    logic [CNT_W-1:0]        rem_next;
    logic                    mode_cur;
    logic signed [CNT_W+1:0] score;
    logic signed [XLEN-1:0]  score_ext;
    logic [XLEN-1:0]         result;
    logic                    ms_legal;

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid & in_ready;

    // The first word of a vector starts from a fresh count of N and the live mode input.
    assign rem_cur  = (state == IDLE) ? matrix_size : remaining;
    assign mode_cur = (state == IDLE) ? en_threshold : mode_act;
    assign k        = (rem_cur > CNT_W'(XLEN)) ? CNT_W'(XLEN) : rem_cur;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        pop = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (CNT_W'(i) < k)
                pop = pop + {{(CNT_W-1){1'b0}}, ~in_data[i]};
        end
    end

    assign acc_next  = ((state == IDLE) ? '0 : acc) + pop;
    assign rem_next  = rem_cur - k;
    assign score     = $signed({1'b0, acc_next, 1'b0}) - $signed({2'b00, matrix_size});
    assign score_ext = {{(XLEN-CNT_W-2){score[CNT_W+1]}}, score};
    assign result    = mode_cur ? {{(XLEN-1){1'b0}}, (score_ext >= act_threshold)}
                                : score_ext;
    assign ms_legal  = (cfg_wdata[XLEN-1:CNT_W] == '0) && (cfg_wdata[CNT_W-1:0] != '0);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            matrix_size   <= CNT_W'(9);
            act_threshold <= '0;
            acc           <= '0;
            remaining     <= CNT_W'(9);
            mode_act      <= 1'b0;
            out_data      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mode_act  <= en_threshold;
                        acc       <= acc_next;
                        remaining <= rem_next;
                        if (rem_next == '0) begin
                            state    <= DONE;
                            out_data <= result;
                        end else begin
                            state <= ACCUM;
                        end
                    end else if (cfg_ms_we) begin
                        if (ms_legal)
                            matrix_size <= cfg_wdata[CNT_W-1:0];
                    end else if (cfg_at_we) begin
                        act_threshold <= cfg_wdata;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc       <= acc_next;
                        remaining <= rem_next;
                        if (rem_next == '0) begin
                            state    <= DONE;
                            out_data <= result;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state    <= IDLE;
                        acc      <= '0;
                        out_data <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_stream_popcount.sv
// Directed self-checking bench for bnn_stream_popcount with hand-computed scores.
module tb_bnn_stream_popcount;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_ms_we = 1'b0;
    logic        cfg_at_we = 1'b0;
    logic [31:0] cfg_wdata = '0;
    logic        en_threshold = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    bnn_stream_popcount #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .cfg_ms_we(cfg_ms_we), .cfg_at_we(cfg_at_we), .cfg_wdata(cfg_wdata),
        .en_threshold(en_threshold),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled on the falling edge.
    task automatic cfg_write(input logic ms, input logic at, input logic [31:0] d);
        @(negedge clk);
        cfg_ms_we = ms; cfg_at_we = at; cfg_wdata = d;
        @(negedge clk);
        cfg_ms_we = 1'b0; cfg_at_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic en);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; en_threshold = en;
        @(negedge clk);
        in_valid = 1'b0; in_data = '0;
    endtask

    task automatic collect(output logic [31:0] d, output bit got);
        got = 1'b0;
        d = 'x;
        for (int c = 0; c < 20 && !got; c++) begin
            if (out_valid === 1'b1) begin
                d = out_data;
                got = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic expect_result(input string name, input logic [31:0] exp);
        logic [31:0] d;
        bit got;
        collect(d, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s: no out_valid within 20 cycles, required 0x%08h", name, exp);
        end else if (d !== exp) begin
            errors++;
            $display("FAIL %s: out_data=0x%08h required 0x%08h", name, d, exp);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: ready/valid/busy=%b required 100", {in_ready, out_valid, busy});
        end
        checks++;
        if (out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_out_data: 0x%08h required 0x00000000", out_data);
        end
    endtask

    task automatic test_single_word();
        send_word(32'h0000_0000, 1'b0);
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b110) begin
            errors++;
            $display("FAIL single_latency: valid/busy/ready=%b required 110", {out_valid, busy, in_ready});
        end
        expect_result("single_plus9", 32'd9);
        checks++;
        if (out_data !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_handshake: out_data=0x%08h in_ready=%b required 0 and 1", out_data, in_ready);
        end
        send_word(32'h0000_01FF, 1'b0);
        expect_result("single_minus9", 32'hFFFF_FFF7);
    endtask

    task automatic test_multi_word();
        cfg_write(1'b1, 1'b0, 32'd40);
        send_word(32'h0000_0000, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL multi_accum: out_valid=%b busy=%b required 0 and 1", out_valid, busy);
        end
        // Mode change on the final word must not switch the vector to activation output.
        send_word(32'hFFFF_FF00, 1'b1);
        expect_result("multi_plus40", 32'd40);
        send_word(32'hFFFF_FFFF, 1'b0);
        repeat (3) @(negedge clk);
        send_word(32'h0000_00F0, 1'b0);
        expect_result("multi_minus32_bubbles", 32'hFFFF_FFE0);
    endtask

    task automatic test_threshold();
        cfg_write(1'b0, 1'b1, 32'd1);
        cfg_write(1'b1, 1'b0, 32'd9);
        send_word(32'h0000_0001, 1'b1);
        expect_result("thr_score7_t1", 32'd1);
        send_word(32'h0000_00FF, 1'b1);
        expect_result("thr_scorem7_t1", 32'd0);
        cfg_write(1'b0, 1'b1, 32'hFFFF_FFF9);
        send_word(32'h0000_00FF, 1'b1);
        expect_result("thr_scorem7_tm7", 32'd1);
    endtask

    task automatic test_config_rules();
        cfg_write(1'b1, 1'b1, 32'd5);
        send_word(32'h0000_0000, 1'b0);
        expect_result("cfg_both_n5", 32'd5);
        send_word(32'h0000_001F, 1'b1);
        expect_result("cfg_both_t_kept", 32'd1);
        cfg_write(1'b1, 1'b0, 32'd0);
        send_word(32'h0000_0000, 1'b0);
        expect_result("cfg_n0_ignored", 32'd5);
        cfg_write(1'b1, 1'b0, 32'h0001_0000);
        send_word(32'h0000_0000, 1'b0);
        expect_result("cfg_n_big_ignored", 32'd5);
        // Write during ACCUM must be dropped for this and the next vector.
        cfg_write(1'b1, 1'b0, 32'd40);
        send_word(32'h0000_0000, 1'b0);
        cfg_write(1'b1, 1'b0, 32'd3);
        send_word(32'h0000_0000, 1'b0);
        expect_result("cfg_accum_cur", 32'd40);
        send_word(32'h0000_0000, 1'b0);
        send_word(32'h0000_0000, 1'b0);
        expect_result("cfg_accum_next", 32'd40);
        // Write coincident with the first word acceptance is also dropped.
        @(negedge clk);
        in_valid = 1'b1; in_data = '0; en_threshold = 1'b0;
        cfg_ms_we = 1'b1; cfg_wdata = 32'd3;
        @(negedge clk);
        in_valid = 1'b0; cfg_ms_we = 1'b0; cfg_wdata = '0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL cfg_same_cycle: out_valid=%b required 0", out_valid);
        end
        send_word(32'h0000_0000, 1'b0);
        expect_result("cfg_same_cycle_result", 32'd40);
        cfg_write(1'b1, 1'b0, 32'd9);
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        out_ready = 1'b0;
        send_word(32'h0000_0003, 1'b0);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'd5 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold: cycle %0d valid=%b data=0x%08h ready=%b required 1 0x00000005 0",
                         c, out_valid, out_data, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b required 1 and 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_vector();
        bit seen;
        seen = 1'b0;
        cfg_write(1'b1, 1'b0, 32'd64);
        send_word(32'h0000_0000, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: busy=%b out_valid=%b required 0 and 0", busy, out_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_result: out_valid seen=1 required 0");
        end
        send_word(32'h0000_0000, 1'b0);
        expect_result("reset_fresh_n9", 32'd9);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_multi_word();
        test_threshold();
        test_config_rules();
        test_backpressure();
        test_reset_mid_vector();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
